// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DMEM_MEM_BYTES = 64;
    localparam int unsigned DMEM_DATA_W    = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_t;

    // Requester identifier: 0 = r0, 1 = r1.
    typedef logic req_id_t;

    // A doubleword access faults when misaligned or when it would run past the last doubleword.
    function automatic logic dw_fault(input logic [63:0] addr, input logic [63:0] last_dw);
        return (addr[2:0] != 3'd0) || (addr > last_dw);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; the pointer names the requester that wins the next tie.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       gnt_en,
    output logic [1:0] grant
);

    req_id_t prio_q;
    req_id_t prio_d;

    // Pick the winner: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    // Hand priority to the requester that was not just granted.
    always_comb begin
        prio_d = prio_q;
        if (gnt_en && (grant != 2'b00)) begin
            prio_d = grant[0];
        end
    end

    // Pointer register; requester 0 wins the first contention after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: IDLE captures, ACCESS drives memory, RESP answers.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DMEM_MEM_BYTES,
    parameter int unsigned DATA_W    = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [63:0]       r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [63:0]       r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [63:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [63:0] LAST_DW = 64'(MEM_BYTES - 8);

    dmem_state_t       state_q, state_d;
    req_id_t           id_q, id_d;
    logic              we_q, we_d;
    logic [63:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              arb_en;
    logic [1:0]        arb_grant;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({r1_req, r0_req}),
        .gnt_en  (arb_en),
        .grant   (arb_grant)
    );

    // Next state, request capture in IDLE and read-data capture at the end of ACCESS.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        arb_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    arb_en  = 1'b1;
                    state_d = ST_ACCESS;
                    if (arb_grant[1]) begin
                        id_d    = 1'b1;
                        we_d    = r1_we;
                        addr_d  = r1_addr;
                        wdata_d = r1_wdata;
                    end else begin
                        id_d    = 1'b0;
                        we_d    = r0_we;
                        addr_d  = r0_addr;
                        wdata_d = r0_wdata;
                    end
                    fault_d = dw_fault(addr_d, LAST_DW);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                rdata_d = (!we_q && !fault_q) ? mem_rdata : '0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from state so reset clears them, and aborts a write, asynchronously.
    always_comb begin
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        r0_rdata  = '0;
        r1_rdata  = '0;
        r0_err    = 1'b0;
        r1_err    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        unique case (state_q)
            ST_ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_write = we_q && !fault_q;
                mem_read  = !we_q && !fault_q;
                r0_gnt    = !id_q;
                r1_gnt    = id_q;
            end
            ST_RESP: begin
                if (id_q) begin
                    r1_rvalid = 1'b1;
                    r1_rdata  = rdata_q;
                    r1_err    = fault_q;
                end else begin
                    r0_rvalid = 1'b1;
                    r0_rdata  = rdata_q;
                    r0_err    = fault_q;
                end
            end
            default: ;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a scoreboard of expected responses and a behavioural memory.
module tb_dmem_arbiter;

    typedef struct {
        logic        id;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [63:0] r0_rdata, r1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic        mem_load;
    logic [63:0] mem [8];
    logic [63:0] ref_mem [8];
    exp_t        sb [$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          gid [4];
    int          gcyc [4];
    int          ng;
    int          t0;
    int          k;
    logic        got;

    dmem_arbiter #(.MEM_BYTES(64), .DATA_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .r0_req    (r0_req),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r0_err    (r0_err),
        .r1_req    (r1_req),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .r1_err    (r1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Eight-doubleword memory: combinational read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[5:3]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) mem[i] <= 64'(i) + 64'd7;
        end else if (mem_write) begin
            mem[mem_addr[5:3]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic id, input logic req, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
        if (id) begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end else begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end
    endtask

    // Push the response the model predicts for one access.
    task automatic expect_resp(input logic id, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata);
        exp_t e;
        logic f;
        f       = (addr[2:0] != 3'd0) || (addr > 64'd56);
        e.id    = id;
        e.err   = f;
        e.rdata = (!we && !f) ? ref_mem[addr[5:3]] : 64'd0;
        if (we && !f) ref_mem[addr[5:3]] = wdata;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and score any response on it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (r0_rvalid || r1_rvalid) begin
            check("rvalid_single", {63'd0, r0_rvalid & r1_rvalid}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rvalid_id", {63'd0, r1_rvalid}, {63'd0, e.id});
                if (r1_rvalid) begin
                    check("r1_rdata", r1_rdata, e.rdata);
                    check("r1_err", {63'd0, r1_err}, {63'd0, e.err});
                    check("r0_quiet", r0_rdata | {63'd0, r0_err}, 64'd0);
                end else begin
                    check("r0_rdata", r0_rdata, e.rdata);
                    check("r0_err", {63'd0, r0_err}, {63'd0, e.err});
                    check("r1_quiet", r1_rdata | {63'd0, r1_err}, 64'd0);
                end
            end
        end
    endtask

    // One complete access from an idle arbiter, checking latency and memory strobes.
    task automatic access(input logic id, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata);
        int   n;
        logic g;
        logic f;
        f = (addr[2:0] != 3'd0) || (addr > 64'd56);
        @(posedge clk);
        #1;
        drive(id, 1'b1, we, addr, wdata);
        expect_resp(id, we, addr, wdata);
        n = 0;
        g = 1'b0;
        while (n < 8 && !g) begin
            tick();
            n++;
            g = id ? r1_gnt : r0_gnt;
        end
        check("gnt_latency", 64'(n), 64'd2);
        check("other_gnt", {63'd0, id ? r0_gnt : r1_gnt}, 64'd0);
        check("mem_write", {63'd0, mem_write}, {63'd0, we && !f});
        check("mem_read", {63'd0, mem_read}, {63'd0, !we && !f});
        if (!f) check("mem_addr", mem_addr, addr);
        drive(id, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        check("rvalid_latency", {63'd0, id ? r1_rvalid : r0_rvalid}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 64'(i) + 64'd7;
        reset_n  = 1'b0;
        mem_load = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'd16, 64'd0);

        // Reset: all outputs quiet even with both requests held.
        tick();
        tick();
        check("rst_gnt", {62'd0, r1_gnt, r0_gnt}, 64'd0);
        check("rst_rvalid", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
        check("rst_strobes", {62'd0, mem_write, mem_read}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_rdata", r0_rdata | r1_rdata, 64'd0);

        // Continuous contention from reset: r0, r1, r0, r1, three cycles apart.
        expect_resp(1'b0, 1'b0, 64'd0, 64'd0);
        expect_resp(1'b1, 1'b0, 64'd16, 64'd0);
        expect_resp(1'b0, 1'b0, 64'd0, 64'd0);
        expect_resp(1'b1, 1'b0, 64'd16, 64'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mem_load = 1'b0;
        ng = 0;
        for (k = 0; k < 20 && ng < 4; k++) begin
            tick();
            if (r0_gnt || r1_gnt) begin
                gid[ng]  = r1_gnt ? 1 : 0;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        check("rr_grant_count", 64'(ng), 64'd4);
        for (int i = 0; i < ng; i++) check("rr_order", 64'(gid[i]), 64'(i % 2));
        for (int i = 1; i < ng; i++) check("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        tick();
        tick();

        // Store then load at address 8.
        access(1'b0, 1'b1, 64'd8, 64'h0000_0000_0000_00AA);
        access(1'b0, 1'b0, 64'd8, 64'd0);

        // Faulted loads: misaligned and past the end.
        access(1'b1, 1'b0, 64'd12, 64'd0);
        access(1'b1, 1'b0, 64'd64, 64'd0);

        // Last legal doubleword.
        access(1'b0, 1'b1, 64'd56, 64'hFFFF_FFFF_FFFF_FFFF);
        access(1'b0, 1'b0, 64'd56, 64'd0);

        // r1 arrives while r0 is in ACCESS: served only after r0's RESP.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b0, 64'd8, 64'd0);
        expect_resp(1'b0, 1'b0, 64'd8, 64'd0);
        got = 1'b0;
        for (k = 0; k < 8 && !got; k++) begin
            tick();
            got = r0_gnt;
        end
        check("late_r0_gnt", {63'd0, got}, 64'd1);
        t0 = cyc;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'd16, 64'd0);
        expect_resp(1'b1, 1'b0, 64'd16, 64'd0);
        got = 1'b0;
        for (k = 0; k < 8 && !got; k++) begin
            tick();
            got = r1_gnt;
        end
        check("late_r1_gap", 64'(cyc - t0), 64'd3);
        check("late_r1_strobe", {62'd0, mem_read, r0_rvalid}, 64'd2);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        check("late_r1_rvalid", {63'd0, r1_rvalid}, 64'd1);

        // Reset in the middle of a write to address 0 aborts it.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 64'd0, 64'h55);
        got = 1'b0;
        for (k = 0; k < 8 && !got; k++) begin
            tick();
            got = r0_gnt;
        end
        check("abort_pre_write", {63'd0, mem_write}, 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_write_drop", {63'd0, mem_write}, 64'd0);
        check("abort_gnt_drop", {63'd0, r0_gnt}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        tick();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        access(1'b0, 1'b0, 64'd0, 64'd0);

        tick();
        tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 64, SHALL set the byte capacity of the attached data memory.
REQ-002 Parameter DATA_W, default 64, SHALL set the doubleword width of every data bus.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rN_req  input  1  (N=0,1) SHALL be the access request, held high until rN_gnt is seen.
REQ-006 rN_we  input  1  SHALL select write (1) or read (0); valid while rN_req is high.
REQ-007 rN_addr  input  64  SHALL be the byte address of the doubleword.
REQ-008 rN_wdata  input  DATA_W  SHALL be the store data.
REQ-009 rN_gnt  output  1  SHALL be a one-cycle pulse acknowledging capture of the request.
REQ-010 rN_rvalid  output  1  SHALL be a one-cycle pulse marking completion.
REQ-011 rN_rdata  output  DATA_W  SHALL be the load data, valid with rN_rvalid.
REQ-012 rN_err  output  1  SHALL flag a faulted access, valid with rN_rvalid.
REQ-013 mem_addr  output  64, mem_wdata  output  DATA_W, mem_write  output  1, mem_read  output  1 SHALL drive the data memory port.
REQ-014 mem_rdata  input  DATA_W  SHALL be the combinational memory read data.

Function
REQ-015 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 In IDLE, one requester SHALL be selected; rN_addr/rN_we/rN_wdata and winner ID SHALL be latched; rN_gnt SHALL pulse in the following (ACCESS) cycle.
REQ-017 Arbitration SHALL be round-robin: with both requesting, the requester not granted last wins; a lone requester wins regardless.
REQ-018 Access is faulted if addr[2:0] != 0 or addr > MEM_BYTES-8.
REQ-019 In ACCESS, mem_addr/mem_wdata SHALL present the latched values; mem_write=we and mem_read=!we, both 0 if faulted; the memory commits the write on the clock edge ending ACCESS.
REQ-020 mem_rdata SHALL be registered on the edge ending ACCESS for non-faulted reads, else the register SHALL load zero.
REQ-021 In RESP, winner's rN_rvalid SHALL be 1, rN_rdata = registered data, rN_err = fault flag; the loser's response outputs SHALL stay 0.
REQ-022 Latency SHALL be: req sampled at edge k -> gnt high in cycle k+1 -> rvalid high in cycle k+2; max one access per 3 cycles.
REQ-023 Requests arriving in ACCESS or RESP SHALL be ignored until the next IDLE; a req dropped before gnt SHALL be treated as withdrawn.
REQ-024 mem_write and mem_read SHALL be 0 in IDLE and RESP.
REQ-025 Round-robin pointer SHALL update only on grant, not on fault.

Reset
REQ-026 While reset_n=0, FSM SHALL be IDLE and every output SHALL be 0, including mem_write/mem_read.
REQ-027 Reset during ACCESS SHALL abort the access: mem_write drops asynchronously so no write commits, and no rvalid is issued for it.
REQ-028 Round-robin pointer SHALL reset so requester 0 wins the first contention.

Structure
REQ-029 FSM state encoding, requester-ID type and the default MEM_BYTES/DATA_W constants SHALL live in shared package dmem_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], gnt_en, grant[1:0], pointer register).

Verification
REQ-031 r0 write addr=8 data=0x0000_0000_0000_00AA, then r0 read addr=8 -> r0_gnt pulses, r0_rvalid two cycles after each req, read rdata=0x...AA, err=0.
REQ-032 r0 and r1 both hold req continuously from reset -> grants alternate r0,r1,r0,r1 with gnts 3 cycles apart.
REQ-033 r1 read addr=12 (misaligned) and addr=64 -> r1_err=1, r1_rdata=0, mem_read stays 0 throughout.
REQ-034 r0 write addr=56 (last legal) data=0xFFFF_FFFF_FFFF_FFFF, read back -> rdata=0xFFFF_FFFF_FFFF_FFFF, err=0.
REQ-035 reset_n pulled low mid-ACCESS of write addr=0 data=0x55 -> mem_write drops immediately, no rvalid, subsequent read addr=0 returns pre-write value 0x07.
REQ-036 r1 raises req during r0's ACCESS cycle -> r1 granted in the cycle after r0's RESP, no overlap of mem strobes.
